// File: rtl/enigma_rotor_sequencer_if.sv
// Handshake and datapath bundle for the Enigma rotor sequencer.
// The master side is the sequencer itself; the slave side is the
// surrounding keyboard, lamp and rotor-lookup logic.
interface enigma_rotor_sequencer_if;
  // Keyboard side
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_char;

  // Lamp side
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_char;

  // Shared rotor-lookup datapath
  logic [2:0] stage;
  logic [4:0] stage_pos;
  logic [4:0] stage_data_out;
  logic [4:0] stage_data_in;

  modport master (
    input  in_valid, in_char, out_ready, stage_data_in,
    output in_ready, out_valid, out_char, stage, stage_pos, stage_data_out
  );

  modport slave (
    output in_valid, in_char, out_ready, stage_data_in,
    input  in_ready, out_valid, out_char, stage, stage_pos, stage_data_out
  );
endinterface

// File: rtl/enigma_rotor_sequencer.sv
// Enigma scrambler controller: owns the three rotor positions, steps them
// odometer-style (with the rotor-1 double step) on every keypress, and
// time-shares one external rotor-lookup datapath over seven passes
// (forward 0..2, reflector, reverse 2..0).
module enigma_rotor_sequencer #(
  parameter int unsigned NOTCH0 = 16,
  parameter int unsigned NOTCH1 = 4,
  parameter int unsigned NOTCH2 = 21
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_pos,
  input  logic [4:0]                      init_pos0,
  input  logic [4:0]                      init_pos1,
  input  logic [4:0]                      init_pos2,
  enigma_rotor_sequencer_if.master        bus,
  output logic [4:0]                      pos0,
  output logic [4:0]                      pos1,
  output logic [4:0]                      pos2,
  output logic                            busy
);

  // Out-of-range notch parameters disable carrying rather than never matching
  // by accident on a truncated compare.
  localparam bit         NotchesValid = (NOTCH0 < 26) && (NOTCH1 < 26) && (NOTCH2 < 26);
  localparam logic [4:0] Notch0       = 5'(NOTCH0);
  localparam logic [4:0] Notch1       = 5'(NOTCH1);
  localparam logic [2:0] LastStage    = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StPass,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] pos0_q, pos0_d;
  logic [4:0] pos1_q, pos1_d;
  logic [4:0] pos2_q, pos2_d;
  logic [4:0] letter_q, letter_d;
  logic [2:0] stage_q, stage_d;
  logic [4:0] out_char_q, out_char_d;

  logic carry1;
  logic carry2;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  // Carry decisions on pre-step positions; rotor 1 also steps on its own notch.
  assign carry1 = NotchesValid && ((pos0_q == Notch0) || (pos1_q == Notch1));
  assign carry2 = NotchesValid && (pos1_q == Notch1);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pos0_q     <= 5'd0;
      pos1_q     <= 5'd0;
      pos2_q     <= 5'd0;
      letter_q   <= 5'd0;
      stage_q    <= 3'd0;
      out_char_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      pos0_q     <= pos0_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      letter_q   <= letter_d;
      stage_q    <= stage_d;
      out_char_q <= out_char_d;
    end
  end

  // Next-state logic: load/accept, step, seven lookup passes, output hold.
  always_comb begin
    state_d    = state_q;
    pos0_d     = pos0_q;
    pos1_d     = pos1_q;
    pos2_d     = pos2_q;
    letter_d   = letter_q;
    stage_d    = stage_q;
    out_char_d = out_char_q;

    unique case (state_q)
      StIdle: begin
        if (load_pos) begin
          // Load wins over a simultaneous letter.
          pos0_d = clamp26(init_pos0);
          pos1_d = clamp26(init_pos1);
          pos2_d = clamp26(init_pos2);
        end else if (bus.in_valid) begin
          letter_d = bus.in_char;
          state_d  = StStep;
        end
      end

      StStep: begin
        if (letter_q > 5'd25) begin
          // Non-letters pass straight through without moving the rotors.
          out_char_d = letter_q;
          state_d    = StDone;
        end else begin
          pos0_d = inc26(pos0_q);
          if (carry1) pos1_d = inc26(pos1_q);
          if (carry2) pos2_d = inc26(pos2_q);
          stage_d = 3'd0;
          state_d = StPass;
        end
      end

      StPass: begin
        letter_d = bus.stage_data_in;
        if (stage_q == LastStage) begin
          out_char_d = bus.stage_data_in;
          stage_d    = 3'd0;
          state_d    = StDone;
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end

      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Datapath drive: rotor position for the active pass, zero outside passes.
  always_comb begin
    bus.stage     = 3'd0;
    bus.stage_pos = 5'd0;
    if (state_q == StPass) begin
      bus.stage = stage_q;
      case (stage_q)
        3'd0:    bus.stage_pos = pos0_q;
        3'd1:    bus.stage_pos = pos1_q;
        3'd2:    bus.stage_pos = pos2_q;
        3'd3:    bus.stage_pos = 5'd0;
        3'd4:    bus.stage_pos = pos2_q;
        3'd5:    bus.stage_pos = pos1_q;
        3'd6:    bus.stage_pos = pos0_q;
        default: bus.stage_pos = 5'd0;
      endcase
    end
  end

  assign bus.stage_data_out = letter_q;
  assign bus.in_ready       = (state_q == StIdle) && !load_pos;
  assign bus.out_valid      = (state_q == StDone);
  assign bus.out_char       = out_char_q;

  assign pos0 = pos0_q;
  assign pos1 = pos1_q;
  assign pos2 = pos2_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
// Directed bench for enigma_rotor_sequencer with a "+1 mod 26" datapath model.
module tb_enigma_rotor_sequencer;

  logic       clk;
  logic       rst;
  logic       load_pos;
  logic [4:0] init_pos0;
  logic [4:0] init_pos1;
  logic [4:0] init_pos2;
  logic [4:0] pos0;
  logic [4:0] pos1;
  logic [4:0] pos2;
  logic       busy;

  int n_cmp;
  int n_err;

  enigma_rotor_sequencer_if bus ();

  enigma_rotor_sequencer #(
    .NOTCH0(16),
    .NOTCH1(4),
    .NOTCH2(21)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_pos (load_pos),
    .init_pos0(init_pos0),
    .init_pos1(init_pos1),
    .init_pos2(init_pos2),
    .bus      (bus),
    .pos0     (pos0),
    .pos1     (pos1),
    .pos2     (pos2),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotor-lookup stand-in: each pass adds one, mod 26.
  always_comb begin
    bus.stage_data_in = (bus.stage_data_out >= 5'd25) ? 5'd0 : bus.stage_data_out + 5'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input int p0, input int p1, input int p2);
    check({tag, ".pos0"}, 32'(pos0), 32'(p0));
    check({tag, ".pos1"}, 32'(pos1), 32'(p1));
    check({tag, ".pos2"}, 32'(pos2), 32'(p2));
  endtask

  task automatic load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    load_pos  = 1'b1;
    init_pos0 = a;
    init_pos1 = b;
    init_pos2 = c;
    tick();
    load_pos = 1'b0;
  endtask

  // Accept one letter, then wait (bounded) for out_valid; lat counts cycles after accept.
  task automatic send(input logic [4:0] c, output int lat);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [4:0] exp_pos [7];

    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    load_pos      = 1'b0;
    init_pos0     = 5'd0;
    init_pos1     = 5'd0;
    init_pos2     = 5'd0;
    bus.in_valid  = 1'b0;
    bus.in_char   = 5'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_pos("reset", 0, 0, 0);
    check("reset.out_valid", 32'(bus.out_valid), 0);
    check("reset.out_char", 32'(bus.out_char), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.stage", 32'(bus.stage), 0);
    check("reset.stage_pos", 32'(bus.stage_pos), 0);
    check("reset.stage_data_out", 32'(bus.stage_data_out), 0);
    check("reset.in_ready", 32'(bus.in_ready), 1);

    // load_pos masks in_ready combinationally
    load_pos = 1'b1;
    #1;
    check("load.in_ready", 32'(bus.in_ready), 0);
    load_pos = 1'b0;
    load(5'd0, 5'd0, 5'd0);

    // Letter 'A' with a cycle-by-cycle pass walk
    exp_pos = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
    bus.in_valid = 1'b1;
    bus.in_char  = 5'd0;
    #1;
    check("a.in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    check("a.step_busy", 32'(busy), 1);
    check("a.step_stage", 32'(bus.stage), 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("a.stage%0d", i), 32'(bus.stage), 32'(i));
      check($sformatf("a.stage_pos%0d", i), 32'(bus.stage_pos), 32'(exp_pos[i]));
      tick();
    end
    check("a.out_valid_t9", 32'(bus.out_valid), 1);
    check("a.out_char", 32'(bus.out_char), 7);
    check_pos("a", 1, 0, 0);
    release_out();
    check("a.out_valid_drop", 32'(bus.out_valid), 0);
    check("a.idle", 32'(busy), 0);

    // Backpressure, with load_pos ignored outside IDLE
    send(5'd5, lat);
    check("bp.latency", 32'(lat), 9);
    for (int i = 0; i < 5; i++) begin
      load_pos  = 1'b1;
      init_pos0 = 5'd9;
      init_pos1 = 5'd9;
      init_pos2 = 5'd9;
      tick();
      check($sformatf("bp.out_valid%0d", i), 32'(bus.out_valid), 1);
      check($sformatf("bp.out_char%0d", i), 32'(bus.out_char), 12);
      check($sformatf("bp.in_ready%0d", i), 32'(bus.in_ready), 0);
      check($sformatf("bp.busy%0d", i), 32'(busy), 1);
    end
    load_pos = 1'b0;
    release_out();
    check("bp.idle_busy", 32'(busy), 0);
    check("bp.idle_out_valid", 32'(bus.out_valid), 0);
    check("bp.idle_in_ready", 32'(bus.in_ready), 1);
    check_pos("bp", 2, 0, 0);

    // Double step
    load(5'd16, 5'd3, 5'd0);
    check_pos("ds.load", 16, 3, 0);
    send(5'd3, lat);
    check("ds1.out_char", 32'(bus.out_char), 10);
    check_pos("ds1", 17, 4, 0);
    release_out();
    send(5'd3, lat);
    check_pos("ds2", 18, 5, 1);
    release_out();

    // Load together with in_valid: load wins, no letter taken
    bus.in_valid = 1'b1;
    bus.in_char  = 5'd2;
    load(5'd25, 5'd25, 5'd25);
    bus.in_valid = 1'b0;
    check("sim.busy", 32'(busy), 0);
    check_pos("sim", 25, 25, 25);
    tick();
    check("sim.still_idle", 32'(busy), 0);

    // Wrap
    send(5'd25, lat);
    check("wrap.out_char", 32'(bus.out_char), 6);
    check_pos("wrap1", 0, 25, 25);
    release_out();
    load(5'd16, 5'd25, 5'd0);
    send(5'd1, lat);
    check_pos("wrap2", 17, 0, 0);
    release_out();

    // Out-of-range init positions load as 0
    load(5'd30, 5'd26, 5'd31);
    check_pos("clamp", 0, 0, 0);

    // Non-letter passes through without stepping
    send(5'd27, lat);
    check("bad.latency", 32'(lat), 2);
    check("bad.out_char", 32'(bus.out_char), 27);
    check_pos("bad", 0, 0, 0);
    release_out();

    // Reset during PASS stage 3
    bus.in_valid = 1'b1;
    bus.in_char  = 5'd4;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst.stage_before", 32'(bus.stage), 3);
    check_pos("rst.before", 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.busy", 32'(busy), 0);
    check("rst.stage", 32'(bus.stage), 0);
    check("rst.out_valid", 32'(bus.out_valid), 0);
    check_pos("rst.after", 0, 0, 0);
    tick();
    check("rst.stay_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_sequencer.md
Name: enigma_rotor_sequencer

Overview:
- Controller for the Enigma scrambler path.
- Owns the three rotor positions and applies odometer stepping with double-step on each keypress.
- Time-shares one external rotor-lookup datapath across seven passes: forward rotors 0..2, reflector, reverse rotors 2..0. The datapath is the forward/reverse rotor and reflector mappings behind a stage mux.
- Sits between keyboard/input logic and the lamp/output logic, with valid/ready handshakes on both sides.

Parameters:
- NOTCH0, 16, position of rotor 0 (fast) at which rotor 1 is carried.
- NOTCH1, 4, position of rotor 1 at which rotor 2 is carried; also the double-step trigger.
- NOTCH2, 21, notch of rotor 2 (unused for stepping; exported for completeness).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_pos  in  1  load init_pos0..2 into rotor positions.
- init_pos0  in  5  initial position for rotor 0.
- init_pos1  in  5  initial position for rotor 1.
- init_pos2  in  5  initial position for rotor 2.
- in_valid  in  1  input letter valid.
- in_ready  out  1  sequencer can accept a letter.
- in_char  in  5  input letter, 0..25.
- stage  out  3  datapath select: 0..2 forward rotor0..2, 3 reflector, 4..6 reverse rotor2..0.
- stage_pos  out  5  position driven to the selected rotor.
- stage_data_out  out  5  letter driven into the datapath.
- stage_data_in  in  5  datapath result; combinational, same cycle.
- out_valid  out  1  encrypted letter valid.
- out_ready  in  1  consumer accepts the letter.
- out_char  out  5  encrypted letter.
- pos0  out  5  current rotor 0 position.
- pos1  out  5  current rotor 1 position.
- pos2  out  5  current rotor 2 position.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State IDLE; pos0..2 = 0.
  - letter register = 0; stage = 0; stage_pos = 0; stage_data_out = 0.
  - out_valid = 0; out_char = 0; busy = 0.
- in_ready = (state == IDLE) & ~load_pos, combinational.
- IDLE:
  - load_pos = 1 loads init_pos values; any value > 25 loads 0.
  - load_pos outside IDLE is ignored.
  - load_pos together with in_valid: the load wins and no letter is accepted that cycle.
  - in_valid & in_ready: latch in_char into the letter register, go to STEP.
- STEP (1 cycle), using pre-step values:
  - pos0 <= pos0 + 1 mod 26.
  - pos1 <= pos1 + 1 mod 26 if pos0 == NOTCH0 or pos1 == NOTCH1 (double step).
  - pos2 <= pos2 + 1 mod 26 if pos1 == NOTCH1.
  - Wrap is 25 -> 0.
  - If the latched letter is > 25: no stepping, skip to DONE with out_char = the latched value.
- PASS (7 cycles, stage counter 0..6):
  - stage_data_out = letter register.
  - stage_pos: stage0 pos0, stage1 pos1, stage2 pos2, stage3 0, stage4 pos2, stage5 pos1, stage6 pos0. Positions are post-step.
  - Each cycle the letter register <= stage_data_in.
  - After stage 6, out_char <= stage_data_in and go to DONE.
  - Outside PASS, stage = 0 and stage_pos = 0.
- DONE:
  - out_valid = 1; out_char is held stable until out_ready = 1.
  - On the handshake cycle go to IDLE; out_valid drops the next cycle.
- Latency: accept at cycle T; STEP at T+1; PASS at T+2..T+8; out_valid first high at T+9. Maximum throughput is 1 letter per 10 cycles with no backpressure.
- Reset in any state aborts the letter immediately and restores all reset values, including the positions.

Test Plan:
- Datapath model stage_data_in = (stage_data_out + 1) mod 26; rst, load 0/0/0, send 'A'(0):
  - pos becomes 1/0/0.
  - stage sequence 0..6 with stage_pos 1,0,0,0,0,0,1.
  - out_char = 7, out_valid at accept + 9.
- Double step: load 16/3/0, send two letters -> positions 17/4/0, then 18/5/1.
- Wrap: load 25/25/25, send one letter -> 0/25/25; load 16/25/0 -> 17/0/0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE:
  - out_valid and out_char stay stable; in_ready = 0; busy = 1.
  - Release -> IDLE the next cycle.
- Simultaneous and invalid inputs:
  - load_pos with in_valid in IDLE -> positions loaded, letter not accepted.
  - in_char = 27 -> no stepping, out_char = 27.
- Reset at PASS stage 3 -> next cycle IDLE, positions 0/0/0, out_valid = 0, stage = 0.
